// File: rtl/demux_dispatch_16b.sv
// Buffers {dest,data} words in a small FIFO and holds each on Y/sel for HOLD cycles. Accept-to-output latency is 1 cycle.
// Backpressure: in_ready = !full, even during a same-cycle pop. Define DISPATCH_CNT_EN to add the word_cnt counter.
module demux_dispatch_16b #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_dest,
  output logic [15:0] Y,
  output logic        sel3,
  output logic        sel2,
  output logic        sel1,
  output logic        sel0,
  output logic        out_valid,
  output logic        busy
`ifdef DISPATCH_CNT_EN
  ,
  output logic [15:0] word_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  logic [19:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [HW-1:0] hold_q;
  logic [15:0]   y_q;
  logic [3:0]    sel_q;
  logic          vld_q;
  logic          push, pop;
  logic [19:0]   head;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign busy      = (count_q != '0) || (state_q == DRIVE);
  assign Y         = y_q;
  assign {sel3, sel2, sel1, sel0} = sel_q;
  assign out_valid = vld_q;

  // A word pushed into an empty FIFO is invisible to pop until the next edge, since count_q is still 0.
  always_comb begin
    push = in_valid && in_ready && !flush;
    pop  = !flush && (count_q != '0) && ((state_q == IDLE) || (hold_q == '0));
    head = mem_q[rd_ptr_q];
  end

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {in_dest, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      y_q     <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      hold_q  <= '0;
      y_q     <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= DRIVE;
            hold_q  <= HW'(HOLD - 1);
            y_q     <= head[15:0];
            sel_q   <= head[19:16];
            vld_q   <= 1'b1;
          end
        end
        DRIVE: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
          end else if (pop) begin
            hold_q <= HW'(HOLD - 1);
            y_q    <= head[15:0];
            sel_q  <= head[19:16];
            vld_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            y_q     <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_CNT_EN
  logic [15:0] word_cnt_q;

  // Counts pops into Y, so a word held for several cycles counts once; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_cnt_q <= '0;
    else if (pop)
      word_cnt_q <= word_cnt_q + 16'd1;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_demux_dispatch_16b.sv
// Directed bench: instance a runs HOLD=1, instance b runs HOLD=3; both DEPTH=4.
module tb_demux_dispatch_16b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic        a_in_valid, a_in_ready, a_out_valid, a_busy;
  logic [15:0] a_in_data, a_y;
  logic [3:0]  a_in_dest;
  wire  [3:0]  a_sel;
  logic        b_in_valid, b_in_ready, b_out_valid, b_busy;
  logic [15:0] b_in_data, b_y;
  logic [3:0]  b_in_dest;
  wire  [3:0]  b_sel;
`ifdef DISPATCH_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] log_y[$];
  logic [3:0]  log_sel[$];

  demux_dispatch_16b #(.DEPTH(4), .HOLD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_dest(a_in_dest),
    .Y(a_y), .sel3(a_sel[3]), .sel2(a_sel[2]), .sel1(a_sel[1]), .sel0(a_sel[0]),
    .out_valid(a_out_valid), .busy(a_busy)
`ifdef DISPATCH_CNT_EN
    , .word_cnt(a_cnt)
`endif
  );

  demux_dispatch_16b #(.DEPTH(4), .HOLD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_dest(b_in_dest),
    .Y(b_y), .sel3(b_sel[3]), .sel2(b_sel[2]), .sel1(b_sel[1]), .sel0(b_sel[0]),
    .out_valid(b_out_valid), .busy(b_busy)
`ifdef DISPATCH_CNT_EN
    , .word_cnt(b_cnt)
`endif
  );

  always @(negedge clk) begin
    if (rst_n && b_out_valid) begin
      log_y.push_back(b_y);
      log_sel.push_back(b_sel);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_dest = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_dest = '0;
    #1 rst_n = 1'b0;
    #2;
    total++; if (a_y !== 16'h0) begin bad++; $display("FAIL rst_y act=%h exp=0000", a_y); end
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL rst_sel act=%b exp=0000", a_sel); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_vld act=%b exp=0", a_out_valid); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy act=%b exp=0", a_busy); end
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL rst_b_vld act=%b exp=0", b_out_valid); end
`ifdef DISPATCH_CNT_EN
    total++; if (a_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt act=%0d exp=0", a_cnt); end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_a_rdy act=%b exp=1", a_in_ready); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL rst_b_rdy act=%b exp=1", b_in_ready); end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL rst_b_busy act=%b exp=0", b_busy); end
  endtask

  task automatic test_single;
    a_in_valid = 1'b1; a_in_data = 16'h01E9; a_in_dest = 4'hB;
    tick;
    a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL single_lat vld act=%b exp=0", a_out_valid); end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL single_busy act=%b exp=1", a_busy); end
    tick;
    total++; if (a_y !== 16'h01E9) begin bad++; $display("FAIL single_y act=%h exp=01e9", a_y); end
    total++; if (a_sel !== 4'b1011) begin bad++; $display("FAIL single_sel act=%b exp=1011", a_sel); end
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL single_vld act=%b exp=1", a_out_valid); end
    tick;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL single_end_vld act=%b exp=0", a_out_valid); end
    total++; if (a_y !== 16'h0) begin bad++; $display("FAIL single_end_y act=%h exp=0000", a_y); end
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL single_end_sel act=%b exp=0000", a_sel); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL single_end_busy act=%b exp=0", a_busy); end
  endtask

  task automatic test_back_to_back;
    a_in_valid = 1'b1; a_in_data = 16'h01E9; a_in_dest = 4'd5;
    tick;
    a_in_data = 16'hBEEF; a_in_dest = 4'd0;
    tick;
    a_in_valid = 1'b0;
    total++; if (a_y !== 16'h01E9) begin bad++; $display("FAIL b2b_y0 act=%h exp=01e9", a_y); end
    total++; if (a_sel !== 4'b0101) begin bad++; $display("FAIL b2b_sel0 act=%b exp=0101", a_sel); end
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_vld0 act=%b exp=1", a_out_valid); end
    tick;
    total++; if (a_y !== 16'hBEEF) begin bad++; $display("FAIL b2b_y1 act=%h exp=beef", a_y); end
    total++; if (a_sel !== 4'b0000) begin bad++; $display("FAIL b2b_sel1 act=%b exp=0000", a_sel); end
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_vld1 act=%b exp=1", a_out_valid); end
    tick;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_vld act=%b exp=0", a_out_valid); end
  endtask

  task automatic test_stream;
    logic [15:0] w [4];
    logic [3:0]  d [4];
    w[0] = 16'h1234; d[0] = 4'd8;
    w[1] = 16'h5678; d[1] = 4'd15;
    w[2] = 16'h9ABC; d[2] = 4'd1;
    w[3] = 16'hFFFF; d[3] = 4'd6;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        a_in_valid = 1'b1; a_in_data = w[i]; a_in_dest = d[i];
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL stream_rdy[%0d] act=%b exp=1", i, a_in_ready); end
      end else begin
        a_in_valid = 1'b0;
      end
      tick;
      if (i >= 1 && i <= 4) begin
        total++; if (a_out_valid !== 1'b1 || a_y !== w[i-1] || a_sel !== d[i-1])
          begin bad++; $display("FAIL stream_out[%0d] act=%b/%h/%h exp=1/%h/%h", i-1, a_out_valid, a_y, a_sel, w[i-1], d[i-1]); end
      end
    end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL stream_end_vld act=%b exp=0", a_out_valid); end
  endtask

  task automatic test_hold_fill;
    logic [15:0] w [7];
    logic [3:0]  d [7];
    int stalls;
    int cyc;
    logic acc;
    int n;
    stalls = 0;
    log_y.delete(); log_sel.delete();
    for (int i = 0; i < 7; i++) begin
      w[i] = 16'hA000 + 16'(i * 16'h0111);
      d[i] = 4'(i + 1);
    end
    for (int i = 0; i < 7; i++) begin
      b_in_valid = 1'b1; b_in_data = w[i]; b_in_dest = d[i];
      cyc = 0;
      while (1) begin
        acc = b_in_ready;
        if (!acc) stalls++;
        tick;
        if (acc) break;
        // Second rejection is the full-FIFO push coinciding with the pop of the third word.
        if (stalls == 2) begin
          total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_rdy act=%b exp=1", b_in_ready); end
          total++; if (b_y !== w[2] || b_out_valid !== 1'b1) begin bad++; $display("FAIL full_pop_y act=%h/%b exp=%h/1", b_y, b_out_valid, w[2]); end
        end
        cyc++;
        if (cyc > 50) begin bad++; total++; $display("FAIL fill_push_timeout word=%0d act=stalled exp=accepted", i); break; end
      end
    end
    b_in_valid = 1'b0;
    total++; if (stalls !== 2) begin bad++; $display("FAIL fill_stalls act=%0d exp=2", stalls); end
    cyc = 0;
    while (b_busy === 1'b1 && cyc < 100) begin tick; cyc++; end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL fill_drain act=busy exp=idle"); end
    tick;
    n = log_y.size();
    total++; if (n !== 21) begin bad++; $display("FAIL fill_len act=%0d exp=21", n); end
    for (int k = 0; k < 21 && k < n; k++) begin
      total++; if (log_y[k] !== w[k/3] || log_sel[k] !== d[k/3])
        begin bad++; $display("FAIL fill_out[%0d] act=%h/%h exp=%h/%h", k, log_y[k], log_sel[k], w[k/3], d[k/3]); end
    end
  endtask

  task automatic test_flush;
    int n;
    log_y.delete(); log_sel.delete();
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1; b_in_data = 16'hC001 + 16'(i); b_in_dest = 4'(i + 1);
      tick;
    end
    total++; if (b_out_valid !== 1'b1 || b_y !== 16'hC001) begin bad++; $display("FAIL flush_pre act=%b/%h exp=1/c001", b_out_valid, b_y); end
    flush = 1'b1; b_in_data = 16'hDEAD; b_in_dest = 4'd9;
    tick;
    flush = 1'b0; b_in_valid = 1'b0;
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL flush_vld act=%b exp=0", b_out_valid); end
    total++; if (b_y !== 16'h0 || b_sel !== 4'h0) begin bad++; $display("FAIL flush_ysel act=%h/%b exp=0000/0000", b_y, b_sel); end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL flush_busy act=%b exp=0", b_busy); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL flush_rdy act=%b exp=1", b_in_ready); end
    n = log_y.size();
    total++; if (n !== 2) begin bad++; $display("FAIL flush_prelog act=%0d exp=2", n); end
    repeat (10) tick;
    total++; if (log_y.size() !== n) begin bad++; $display("FAIL flush_leak act=%0d exp=%0d", log_y.size(), n); end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL flush_idle act=%b exp=0", b_busy); end
  endtask

  task automatic test_async_reset;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #4;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_data = 16'h0700 + 16'(i); a_in_dest = 4'(i);
      tick;
    end
    a_in_valid = 1'b0;
    tick; tick;
`ifdef DISPATCH_CNT_EN
    total++; if (a_cnt !== 16'd3) begin bad++; $display("FAIL cnt_three act=%0d exp=3", a_cnt); end
`endif
    a_in_valid = 1'b1; a_in_data = 16'h5A5A; a_in_dest = 4'd12;
    tick;
    a_in_valid = 1'b0;
    tick;
    total++; if (a_out_valid !== 1'b1 || a_y !== 16'h5A5A) begin bad++; $display("FAIL ar_pre act=%b/%h exp=1/5a5a", a_out_valid, a_y); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_y !== 16'h0) begin bad++; $display("FAIL ar_y act=%h exp=0000", a_y); end
    total++; if (a_sel !== 4'h0) begin bad++; $display("FAIL ar_sel act=%b exp=0000", a_sel); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL ar_vld act=%b exp=0", a_out_valid); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL ar_busy act=%b exp=0", a_busy); end
`ifdef DISPATCH_CNT_EN
    total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL ar_cnt act=%0d exp=0", a_cnt); end
`endif
    @(negedge clk) rst_n = 1'b1;
    tick;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL ar_after_vld act=%b exp=0", a_out_valid); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL ar_after_rdy act=%b exp=1", a_in_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_stream;
    test_hold_fill;
    test_flush;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
